game_multi: RTL and testbench
=============================

GAME_MULTI -- requirements
Module: game_multi

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_RES, 800, active pixels per line.
- V_RES, 600, active lines per frame.
- N_OBJ, 4, object count (2..8); object 0 is the player, objects 1..N_OBJ-1 are bouncers.
- OBJ_W, 8, object width minus 1, in pixels.
- OBJ_H, 20, object height minus 1, in lines.
- SPEED, 1, pixels moved per update (1..15).
- FRAMES_PER_ACTION, 2, frames per position update (>=1).
- ACCEL_CORR_X / ACCEL_CORR_Y, 3 / 1, signed 8-bit offsets added to raw accelerometer data.
- ACCEL_DEAD, 2, dead-zone magnitude for corrected accelerometer data.
- FLASH_FRAMES, 8, frames of background flash after a hit.

REQ-002 Ports, one per line: name, direction, width, meaning.
- pixel_clk, in, 1, pixel clock; sole clock.
- rst_n, in, 1, reset; synchronous, active-low.
- button_c, button_u, button_d, button_l, button_r, in, 1 each, debounced level buttons.
- accel_data_x, accel_data_y, in, 8, signed two's-complement accelerometer data.
- h_coord, in, 11, current pixel column.
- v_coord, in, 10, current pixel line.
- SW, in, 3, background enables (bit0 R, bit1 G, bit2 B).
- red, green, blue, out, 4 each, pixel colour.
- regime, out, 2, current mode.
- hit_count, out, 16, saturating collision count.

Function
REQ-003 Registered end-of-frame pulse eof SHALL be 1 for exactly one cycle, in the cycle after h_coord==H_RES-1 and v_coord==V_RES-1.
REQ-004 The frame counter SHALL increment on each eof and wrap from FRAMES_PER_ACTION-1 to 0; the update strobe upd SHALL be eof while the counter==0, i.e. the first eof after reset, then every FRAMES_PER_ACTION frames.
REQ-005 button_c SHALL be edge-detected: a registered previous value, with a 0->1 transition advancing regime 0 (buttons) -> 1 (accel) -> 2 (pause) -> 0; holding button_c SHALL cause exactly one advance.
REQ-006 Coordinates SHALL be 11-bit unsigned top-left corners; every object SHALL satisfy 0 <= h <= H_RES-1-OBJ_W and 0 <= v <= V_RES-1-OBJ_H at all times.
REQ-007 Player on upd, regime 0: button_l moves left by SPEED, else button_r moves right; button_u moves up, else button_d moves down. Each move SHALL clamp at the REQ-006 bounds without wrapping.
REQ-008 Player on upd, regime 1: use corrected values ax = accel_data_x+ACCEL_CORR_X and ay = accel_data_y+ACCEL_CORR_Y (8-bit wrap, signed). ay > ACCEL_DEAD moves left; ay < -ACCEL_DEAD moves right; ax < -ACCEL_DEAD moves up; ax > ACCEL_DEAD moves down. Each move clamps as in REQ-007.
REQ-009 Bouncer i on upd, regimes 0 and 1: move by SPEED along each axis per its direction bits dh_i and dv_i (1 = +). If the new position would exceed a bound, it SHALL clamp to the bound and invert that axis' direction bit in the same update.
REQ-010 Regime 2 SHALL freeze all positions; the frame counter, flash counter and regime logic SHALL keep running.
REQ-011 Collision: on upd, in regimes 0 and 1, if the player rectangle overlaps any bouncer rectangle (inclusive edges, pre-update coordinates), hit_count SHALL increment by 1 (saturating at 16'hFFFF) and the flash counter SHALL load FLASH_FRAMES. Multiple simultaneous overlaps SHALL count once.
REQ-012 The flash counter SHALL decrement on each eof while nonzero.
REQ-013 Pixel colour SHALL be combinational from h_coord, v_coord and registered state, with this priority:
- player pixel: F/F/F;
- bouncer pixel: F/0/F for odd i, 0/F/F for even i;
- background during flash (counter != 0): F/0/0;
- otherwise each channel 8 if its SW bit is set, else 0.
REQ-014 Coordinate compares SHALL be at least 12 bits wide so that h+OBJ_W never overflows.

Reset
REQ-015 While rst_n==0 at a clock edge:
- regime=0, hit_count=0, frame counter=0, flash counter=0, eof=0, button_c history=0;
- player at ((H_RES-OBJ_W)/2, (V_RES-OBJ_H)/2);
- bouncer i at (i*(H_RES/N_OBJ), V_RES/4) with dh_i=dv_i=1.
REQ-016 Reset SHALL take precedence over upd and button_c edges in the same cycle; a reset mid-frame SHALL abandon any pending update.
REQ-017 Outputs SHALL be valid in the first cycle after rst_n rises; no X may appear on any output.

Verification
REQ-018 Defaults, regime 0, button_r held for 2000 frames: player h increments 1 per 2 frames and stops at 791.
REQ-019 button_c held high for 100 cycles, then released, three times: regime goes 0 -> 1 -> 2 -> 0, one step per press.
REQ-020 Regime 1, accel_data_y=8'hFB (ay=-4): player moves right; accel_data_y=8'hFF (ay=0) with accel_data_x=8'hFF (ax=2): no movement.
REQ-021 Bouncer 1 placed at h=790 with dh=1: the next upd clamps it to 791 and sets dh=0; the following upd gives h=790.
REQ-022 Player overlapping bouncer 2 across 3 updates: hit_count=3; background shows F/0/0 for 8 frames after the last hit; in regime 2, overlap does not change hit_count.

Source files
------------

// File: rtl/game_multi.sv
// Multi-object game core: one steerable player and N_OBJ-1 bouncers drawn over a
// switch-selected background that flashes red after each player/bouncer collision.
module game_multi #(
  parameter int              H_RES             = 800,
  parameter int              V_RES             = 600,
  parameter int              N_OBJ             = 4,
  parameter int              OBJ_W             = 8,
  parameter int              OBJ_H             = 20,
  parameter int              SPEED             = 1,
  parameter int              FRAMES_PER_ACTION = 2,
  parameter logic signed [7:0] ACCEL_CORR_X    = 8'sd3,
  parameter logic signed [7:0] ACCEL_CORR_Y    = 8'sd1,
  parameter int              ACCEL_DEAD        = 2,
  parameter int              FLASH_FRAMES      = 8
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        button_c,
  input  logic        button_u,
  input  logic        button_d,
  input  logic        button_l,
  input  logic        button_r,
  input  logic [7:0]  accel_data_x,
  input  logic [7:0]  accel_data_y,
  input  logic [10:0] h_coord,
  input  logic [9:0]  v_coord,
  input  logic [2:0]  SW,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [1:0]  regime,
  output logic [15:0] hit_count
);

  localparam int HMAX = H_RES - 1 - OBJ_W;
  localparam int VMAX = V_RES - 1 - OBJ_H;
  localparam int FCW  = (FRAMES_PER_ACTION > 1) ? $clog2(FRAMES_PER_ACTION) : 1;
  localparam int FLW  = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
  localparam logic signed [7:0] DEAD_P = 8'(ACCEL_DEAD);
  localparam logic signed [7:0] DEAD_N = -DEAD_P;

  typedef enum logic [1:0] {
    REG_BUTTONS = 2'd0,
    REG_ACCEL   = 2'd1,
    REG_PAUSE   = 2'd2
  } regime_e;

  regime_e           regime_q;
  logic [15:0]       hitCount_q;
  logic [FCW-1:0]    frameCnt_q;
  logic [FLW-1:0]    flashCnt_q;
  logic              eof_q;
  logic              btnC_q;
  logic [10:0]       objH_q [N_OBJ];
  logic [10:0]       objV_q [N_OBJ];
  logic [N_OBJ-1:0]  dh_q;
  logic [N_OBJ-1:0]  dv_q;

  logic [10:0]       objH_d [N_OBJ];
  logic [10:0]       objV_d [N_OBJ];
  logic [N_OBJ-1:0]  dh_d;
  logic [N_OBJ-1:0]  dv_d;
  logic              upd;
  logic              moving;
  logic              hit;
  logic              goL, goR, goU, goD;
  logic signed [7:0] ax;
  logic signed [7:0] ay;

  // All coordinate arithmetic is done at 12 bits so pos+OBJ_W/SPEED cannot wrap.
  function automatic logic [10:0] incClamp(input logic [10:0] pos, input logic [11:0] lim);
    logic [11:0] sum;
    sum = {1'b0, pos} + 12'(SPEED);
    return (sum >= lim) ? lim[10:0] : sum[10:0];
  endfunction

  function automatic logic incHitsBound(input logic [10:0] pos, input logic [11:0] lim);
    return ({1'b0, pos} + 12'(SPEED)) >= lim;
  endfunction

  function automatic logic [10:0] decClamp(input logic [10:0] pos);
    return ({1'b0, pos} <= 12'(SPEED)) ? 11'd0 : pos - 11'(SPEED);
  endfunction

  function automatic logic decHitsBound(input logic [10:0] pos);
    return {1'b0, pos} <= 12'(SPEED);
  endfunction

  function automatic logic overlap(input logic [10:0] ah, input logic [10:0] av,
                                   input logic [10:0] bh, input logic [10:0] bv);
    logic [11:0] ah12, av12, bh12, bv12;
    ah12 = {1'b0, ah};
    av12 = {1'b0, av};
    bh12 = {1'b0, bh};
    bv12 = {1'b0, bv};
    return (ah12 <= bh12 + 12'(OBJ_W)) && (bh12 <= ah12 + 12'(OBJ_W)) &&
           (av12 <= bv12 + 12'(OBJ_H)) && (bv12 <= av12 + 12'(OBJ_H));
  endfunction

  function automatic logic inObj(input logic [11:0] px, input logic [11:0] py,
                                 input logic [10:0] oh, input logic [10:0] ov);
    logic [11:0] oh12, ov12;
    oh12 = {1'b0, oh};
    ov12 = {1'b0, ov};
    return (px >= oh12) && (px <= oh12 + 12'(OBJ_W)) &&
           (py >= ov12) && (py <= ov12 + 12'(OBJ_H));
  endfunction

  function automatic logic [10:0] initH(input int idx);
    int p;
    p = (idx == 0) ? (H_RES - OBJ_W) / 2 : idx * (H_RES / N_OBJ);
    if (p > HMAX) p = HMAX;
    return 11'(p);
  endfunction

  function automatic logic [10:0] initV(input int idx);
    int p;
    p = (idx == 0) ? (V_RES - OBJ_H) / 2 : V_RES / 4;
    if (p > VMAX) p = VMAX;
    return 11'(p);
  endfunction

  // Candidate positions are always computed; the register block only takes
  // them on an update strobe outside pause.
  always_comb begin
    upd    = eof_q && (frameCnt_q == '0);
    moving = upd && (regime_q != REG_PAUSE);
    ax     = $signed(accel_data_x) + ACCEL_CORR_X;
    ay     = $signed(accel_data_y) + ACCEL_CORR_Y;
    goL    = 1'b0;
    goR    = 1'b0;
    goU    = 1'b0;
    goD    = 1'b0;
    hit    = 1'b0;
    objH_d = objH_q;
    objV_d = objV_q;
    dh_d   = dh_q;
    dv_d   = dv_q;

    if (regime_q == REG_BUTTONS) begin
      goL = button_l;
      goR = !button_l && button_r;
      goU = button_u;
      goD = !button_u && button_d;
    end else if (regime_q == REG_ACCEL) begin
      goL = ay > DEAD_P;
      goR = ay < DEAD_N;
      goU = ax < DEAD_N;
      goD = ax > DEAD_P;
    end

    for (int i = 1; i < N_OBJ; i++) begin
      if (overlap(objH_q[0], objV_q[0], objH_q[i], objV_q[i])) hit = 1'b1;
    end

    if (goL)      objH_d[0] = decClamp(objH_q[0]);
    else if (goR) objH_d[0] = incClamp(objH_q[0], 12'(HMAX));
    if (goU)      objV_d[0] = decClamp(objV_q[0]);
    else if (goD) objV_d[0] = incClamp(objV_q[0], 12'(VMAX));

    // Reaching a wall counts as a bounce, so the direction flips on arrival.
    for (int i = 1; i < N_OBJ; i++) begin
      if (dh_q[i]) begin
        objH_d[i] = incClamp(objH_q[i], 12'(HMAX));
        if (incHitsBound(objH_q[i], 12'(HMAX))) dh_d[i] = 1'b0;
      end else begin
        objH_d[i] = decClamp(objH_q[i]);
        if (decHitsBound(objH_q[i])) dh_d[i] = 1'b1;
      end
      if (dv_q[i]) begin
        objV_d[i] = incClamp(objV_q[i], 12'(VMAX));
        if (incHitsBound(objV_q[i], 12'(VMAX))) dv_d[i] = 1'b0;
      end else begin
        objV_d[i] = decClamp(objV_q[i]);
        if (decHitsBound(objV_q[i])) dv_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      regime_q   <= REG_BUTTONS;
      hitCount_q <= '0;
      frameCnt_q <= '0;
      flashCnt_q <= '0;
      eof_q      <= 1'b0;
      btnC_q     <= 1'b0;
      dh_q       <= '1;
      dv_q       <= '1;
      for (int i = 0; i < N_OBJ; i++) begin
        objH_q[i] <= initH(i);
        objV_q[i] <= initV(i);
      end
    end else begin
      eof_q  <= (h_coord == 11'(H_RES - 1)) && (v_coord == 10'(V_RES - 1));
      btnC_q <= button_c;

      if (button_c && !btnC_q) begin
        case (regime_q)
          REG_BUTTONS: regime_q <= REG_ACCEL;
          REG_ACCEL:   regime_q <= REG_PAUSE;
          default:     regime_q <= REG_BUTTONS;
        endcase
      end

      if (eof_q) begin
        frameCnt_q <= (frameCnt_q == FCW'(FRAMES_PER_ACTION - 1)) ? '0 : frameCnt_q + FCW'(1);
      end

      if (moving && hit) begin
        flashCnt_q <= FLW'(FLASH_FRAMES);
        if (hitCount_q != 16'hFFFF) hitCount_q <= hitCount_q + 16'd1;
      end else if (eof_q && (flashCnt_q != '0)) begin
        flashCnt_q <= flashCnt_q - FLW'(1);
      end

      if (moving) begin
        objH_q <= objH_d;
        objV_q <= objV_d;
        dh_q   <= dh_d;
        dv_q   <= dv_d;
      end
    end
  end

  // Priority: player, then lowest-numbered bouncer, then flash, then switches.
  always_comb begin
    logic [11:0] px, py;
    px    = {1'b0, h_coord};
    py    = {2'b00, v_coord};
    red   = SW[0] ? 4'h8 : 4'h0;
    green = SW[1] ? 4'h8 : 4'h0;
    blue  = SW[2] ? 4'h8 : 4'h0;
    if (flashCnt_q != '0) begin
      red   = 4'hF;
      green = 4'h0;
      blue  = 4'h0;
    end
    for (int i = N_OBJ - 1; i >= 1; i--) begin
      if (inObj(px, py, objH_q[i], objV_q[i])) begin
        red   = (i % 2 == 1) ? 4'hF : 4'h0;
        green = (i % 2 == 1) ? 4'h0 : 4'hF;
        blue  = 4'hF;
      end
    end
    if (inObj(px, py, objH_q[0], objV_q[0])) begin
      red   = 4'hF;
      green = 4'hF;
      blue  = 4'hF;
    end
  end

  assign regime    = regime_q;
  assign hit_count = hitCount_q;

endmodule

// File: tb/tb_game_multi.sv
// Directed bench for game_multi: frames are produced by jumping the pixel
// coordinates to the last pixel, and a behavioural model predicts every output.
module tb_game_multi;

  localparam int N    = 4;
  localparam int HMAX = 791;
  localparam int VMAX = 579;
  localparam int FPA  = 2;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic        button_c, button_u, button_d, button_l, button_r;
  logic [7:0]  accel_data_x, accel_data_y;
  logic [10:0] h_coord;
  logic [9:0]  v_coord;
  logic [2:0]  SW;
  logic [3:0]  red, green, blue;
  logic [1:0]  regime;
  logic [15:0] hit_count;

  int checks = 0;
  int errors = 0;

  int mH [N];
  int mV [N];
  bit mDh [N];
  bit mDv [N];
  int mRegime, mHits, mFrame, mFlash;

  logic [11:0] expQ [$];
  string       tagQ [$];

  game_multi dut (
    .pixel_clk    (pixel_clk),
    .rst_n        (rst_n),
    .button_c     (button_c),
    .button_u     (button_u),
    .button_d     (button_d),
    .button_l     (button_l),
    .button_r     (button_r),
    .accel_data_x (accel_data_x),
    .accel_data_y (accel_data_y),
    .h_coord      (h_coord),
    .v_coord      (v_coord),
    .SW           (SW),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .regime       (regime),
    .hit_count    (hit_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic compareVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit u, input bit d, input bit l, input bit r);
    button_u = u;
    button_d = d;
    button_l = l;
    button_r = r;
  endtask

  function automatic bit covers(input int i, input int x, input int y);
    return x >= mH[i] && x <= mH[i] + 8 && y >= mV[i] && y <= mV[i] + 20;
  endfunction

  function automatic logic [11:0] expColour(input int x, input int y);
    if (covers(0, x, y)) return 12'hFFF;
    for (int i = 1; i < N; i++)
      if (covers(i, x, y)) return (i % 2 == 1) ? 12'hF0F : 12'h0FF;
    if (mFlash > 0) return 12'hF00;
    return {(SW[0] ? 4'h8 : 4'h0), (SW[1] ? 4'h8 : 4'h0), (SW[2] ? 4'h8 : 4'h0)};
  endfunction

  task automatic modelReset();
    mRegime = 0; mHits = 0; mFrame = 0; mFlash = 0;
    mH[0] = 396; mV[0] = 290;
    for (int i = 1; i < N; i++) begin
      mH[i] = i * 200; mV[i] = 150; mDh[i] = 1; mDv[i] = 1;
    end
  endtask

  task automatic modelEof();
    bit upd, hit;
    byte ax, ay;
    upd = (mFrame == 0);
    mFrame = (mFrame + 1) % FPA;
    if (mFlash > 0) mFlash--;
    if (upd && mRegime != 2) begin
      hit = 0;
      for (int i = 1; i < N; i++)
        if (mH[0] <= mH[i] + 8 && mH[i] <= mH[0] + 8 && mV[0] <= mV[i] + 20 && mV[i] <= mV[0] + 20)
          hit = 1;
      if (mRegime == 0) begin
        if (button_l) mH[0] = (mH[0] > 0) ? mH[0] - 1 : 0;
        else if (button_r) mH[0] = (mH[0] < HMAX) ? mH[0] + 1 : HMAX;
        if (button_u) mV[0] = (mV[0] > 0) ? mV[0] - 1 : 0;
        else if (button_d) mV[0] = (mV[0] < VMAX) ? mV[0] + 1 : VMAX;
      end else begin
        ax = $signed(accel_data_x) + 8'sd3;
        ay = $signed(accel_data_y) + 8'sd1;
        if (ay > 2) mH[0] = (mH[0] > 0) ? mH[0] - 1 : 0;
        else if (ay < -2) mH[0] = (mH[0] < HMAX) ? mH[0] + 1 : HMAX;
        if (ax < -2) mV[0] = (mV[0] > 0) ? mV[0] - 1 : 0;
        else if (ax > 2) mV[0] = (mV[0] < VMAX) ? mV[0] + 1 : VMAX;
      end
      for (int i = 1; i < N; i++) begin
        if (mDh[i]) begin
          if (mH[i] + 1 >= HMAX) begin mH[i] = HMAX; mDh[i] = 0; end else mH[i]++;
        end else begin
          if (mH[i] - 1 <= 0) begin mH[i] = 0; mDh[i] = 1; end else mH[i]--;
        end
        if (mDv[i]) begin
          if (mV[i] + 1 >= VMAX) begin mV[i] = VMAX; mDv[i] = 0; end else mV[i]++;
        end else begin
          if (mV[i] - 1 <= 0) begin mV[i] = 0; mDv[i] = 1; end else mV[i]--;
        end
      end
      if (hit) begin
        if (mHits < 65535) mHits++;
        mFlash = 8;
      end
    end
  endtask

  task automatic runFrame();
    h_coord = 11'd799; v_coord = 10'd599;
    tick();
    h_coord = 11'd0; v_coord = 10'd0;
    tick();
    modelEof();
  endtask

  task automatic runFrames(input int n);
    for (int k = 0; k < n; k++) runFrame();
  endtask

  task automatic checkOutput(input string tag, input int x, input int y);
    logic [11:0] exp;
    string t;
    h_coord = 11'(x); v_coord = 10'(y);
    expQ.push_back(expColour(x, y));
    tagQ.push_back(tag);
    tick();
    exp = expQ.pop_front();
    t = tagQ.pop_front();
    compareVal(t, {4'h0, red, green, blue}, {4'h0, exp});
    h_coord = 11'd0; v_coord = 10'd0;
  endtask

  task automatic checkPlayer(input string tag);
    checkOutput({tag, "_tl"}, mH[0], mV[0]);
    checkOutput({tag, "_br"}, mH[0] + 8, mV[0] + 20);
    checkOutput({tag, "_right"}, mH[0] + 9, mV[0]);
    if (mH[0] > 0) checkOutput({tag, "_left"}, mH[0] - 1, mV[0]);
  endtask

  task automatic pressC();
    button_c = 1'b1;
    tick();
    mRegime = (mRegime + 1) % 3;
    repeat (99) tick();
    button_c = 1'b0;
    tick();
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    button_c = 1'b0;
    applyStimulus(0, 0, 0, 0);
    accel_data_x = 8'hFD;
    accel_data_y = 8'hFF;
    h_coord = 11'd0; v_coord = 10'd0;
    SW = 3'b101;

    $display("[TB] reset state");
    applyReset();
    compareVal("reset_regime", {14'd0, regime}, 16'(mRegime));
    compareVal("reset_hits", hit_count, 16'(mHits));
    checkPlayer("reset_player");
    checkOutput("reset_bouncer1", 200, 150);
    checkOutput("reset_bouncer2", 400, 150);
    checkOutput("reset_bg", 0, 0);

    $display("[TB] regime cycling with held button_c");
    for (int p = 0; p < 3; p++) begin
      pressC();
      compareVal($sformatf("regime_press%0d", p), {14'd0, regime}, 16'(mRegime));
    end

    $display("[TB] button_r held for 2000 frames");
    applyStimulus(0, 0, 0, 1);
    runFrames(20);
    checkPlayer("right_early");
    runFrames(1980);
    checkPlayer("right_end");
    checkOutput("right_at_791", 791, mV[0]);
    compareVal("right_hits", hit_count, 16'(mHits));
    applyStimulus(0, 0, 0, 0);

    $display("[TB] accelerometer regime");
    applyReset();
    pressC();
    compareVal("accel_regime", {14'd0, regime}, 16'(mRegime));
    accel_data_x = 8'hFD; accel_data_y = 8'hFB;
    runFrames(10);
    checkPlayer("accel_right");
    accel_data_x = 8'hFF; accel_data_y = 8'hFF;
    runFrames(10);
    checkPlayer("accel_still");
    accel_data_x = 8'h00; accel_data_y = 8'h03;
    runFrames(4);
    checkPlayer("accel_left_down");
    accel_data_x = 8'hFD; accel_data_y = 8'hFF;

    $display("[TB] bouncer 1 at right wall");
    applyReset();
    for (int n = 0; n < 2000 && mH[1] != 790; n++) runFrame();
    runFrames(2);
    checkOutput("bounce_791", 791, mV[1]);
    checkOutput("bounce_799", 799, mV[1]);
    runFrames(2);
    checkOutput("bounce_790", 790, mV[1]);
    checkOutput("bounce_799_out", 799, mV[1]);
    checkOutput("bounce_798", 798, mV[1]);

    $display("[TB] collisions, flash and pause");
    applyReset();
    applyStimulus(1, 0, 0, 1);
    runFrames(126);
    compareVal("hits_three", hit_count, 16'(mHits));
    compareVal("hits_three_abs", hit_count, 16'd3);
    applyStimulus(0, 0, 0, 0);
    pressC();
    pressC();
    compareVal("pause_regime", {14'd0, regime}, 16'(mRegime));
    checkOutput("flash_0", 0, 0);
    for (int f = 1; f <= 8; f++) begin
      runFrame();
      checkOutput($sformatf("flash_%0d", f), 0, 0);
    end
    runFrames(20);
    compareVal("pause_hits", hit_count, 16'(mHits));
    checkPlayer("pause_player");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
